// File: rtl/led_flash_bank_if.sv
// ---------------------------------------------------------------------------
// led_flash_bank_if
//
// Groups the event inputs, the per-channel controls and the LED status outputs
// of led_flash_bank into one bundle. The clock and the reset stay plain ports
// on the module.
//
// Signals (NCH = number of channels):
//   event_i      [NCH-1:0]    per-channel single-cycle event strobes
//   mode_i       [2*NCH-1:0]  per-channel display mode, channel c at [2c+1:2c]
//                             (00 flash, 01 toggle, 10 level, 11 off)
//   lamp_test_i               forces every LED on while set
//   clear_i                   clears the sticky coalesced flags
//   led_o        [NCH-1:0]    registered LED drive
//   busy_o       [NCH-1:0]    flash state machine is not idle
//   coalesced_o  [NCH-1:0]    sticky: an event was merged into a pending flash
//
// Modports:
//   master - the event source / controller side (drives the inputs)
//   slave  - the led_flash_bank side (drives the LED and status outputs)
// ---------------------------------------------------------------------------
interface led_flash_bank_if #(
    parameter int NCH = 8
);
    logic [NCH-1:0]   event_i;
    logic [2*NCH-1:0] mode_i;
    logic             lamp_test_i;
    logic             clear_i;
    logic [NCH-1:0]   led_o;
    logic [NCH-1:0]   busy_o;
    logic [NCH-1:0]   coalesced_o;

    modport master (
        output event_i,
        output mode_i,
        output lamp_test_i,
        output clear_i,
        input  led_o,
        input  busy_o,
        input  coalesced_o
    );

    modport slave (
        input  event_i,
        input  mode_i,
        input  lamp_test_i,
        input  clear_i,
        output led_o,
        output busy_o,
        output coalesced_o
    );
endinterface : led_flash_bank_if

// File: rtl/led_flash_bank.sv
// ---------------------------------------------------------------------------
// led_flash_bank
//
// Multi-channel LED flasher. Each channel turns single-cycle events into a
// visible LED pulse with a programmable on-time and a minimum off-gap, or
// drives its LED in toggle, level or off mode. A burst of events during a
// flash yields at most one extra flash; any further event is merged and
// reported on the sticky coalesced flag. A global lamp test forces all LEDs
// on without disturbing the channel state.
//
// Parameters:
//   NCH         number of channels
//   ON_CYCLES   LED on-time per flash, clock cycles (>= 1)
//   GAP_CYCLES  minimum LED off-time after a flash, clock cycles (0 = no gap)
//   CNT_WIDTH   down-counter width, must hold max(ON_CYCLES, GAP_CYCLES)-1
//   HB_DIV      heartbeat divider exponent (heartbeat build only)
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   bus          led_flash_bank_if.slave: event_i, mode_i, lamp_test_i,
//                clear_i in; led_o, busy_o, coalesced_o out
//   heartbeat_o  free-running heartbeat, toggles every 2^HB_DIV cycles
//                (present only when LED_FLASH_HEARTBEAT_EN is defined)
//
// Build option:
//   LED_FLASH_HEARTBEAT_EN  adds heartbeat_o and its HB_DIV-bit counter.
// ---------------------------------------------------------------------------
module led_flash_bank #(
    parameter int NCH        = 8,
    parameter int ON_CYCLES  = 4000000,
    parameter int GAP_CYCLES = 2000000,
    parameter int CNT_WIDTH  = 23,
    parameter int HB_DIV     = 21
) (
    input  logic            clock,
    input  logic            reset_n,
    led_flash_bank_if.slave bus
`ifdef LED_FLASH_HEARTBEAT_EN
    ,
    output logic            heartbeat_o
`endif
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (ON_CYCLES < 1) begin : g_chk_on
        $error("led_flash_bank: ON_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_chk_gap
        $error("led_flash_bank: GAP_CYCLES must be >= 0");
    end
    if ((ON_CYCLES - 1) >= (1 << CNT_WIDTH) || (GAP_CYCLES - 1) >= (1 << CNT_WIDTH)) begin : g_chk_cnt
        $error("led_flash_bank: CNT_WIDTH too small for ON_CYCLES/GAP_CYCLES");
    end
    if (HB_DIV < 1) begin : g_chk_hb
        $error("led_flash_bank: HB_DIV must be >= 1");
    end

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] MODE_FLASH  = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_LEVEL  = 2'b10;

    // Counter load values: the counter runs load..0, so a phase lasts
    // exactly load+1 cycles.
    localparam logic [CNT_WIDTH-1:0] ON_LOAD  = CNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD = CNT_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ON   = 2'b01,
        S_GAP  = 2'b10
    } state_t;

    logic [NCH-1:0] led_vec;
    logic [NCH-1:0] busy_vec;
    logic [NCH-1:0] coal_vec;

    // -----------------------------------------------------------------------
    // Per-channel logic. Channels share nothing but lamp_test_i and clear_i.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t               state_q, state_d;
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic                 pend_q, pend_d;
            logic                 tog_q, tog_d;
            logic                 coal_q, coal_d;
            logic                 led_q, led_d;
            logic [1:0]           mode_q;
            logic [1:0]           mode_ch;
            logic                 ev;
            logic                 chg;
            logic                 coal_set;
            logic                 under_d;

            assign mode_ch = bus.mode_i[2*gi +: 2];
            assign ev      = bus.event_i[gi];
            // A cycle in which the requested mode differs from the one in
            // force is spent resetting the channel; the new mode acts from
            // the next cycle on.
            assign chg     = (mode_ch != mode_q);

            // ---------------------------------------------------------------
            // State register
            // ---------------------------------------------------------------
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    pend_q  <= 1'b0;
                    tog_q   <= 1'b0;
                    coal_q  <= 1'b0;
                    led_q   <= 1'b0;
                    mode_q  <= MODE_FLASH;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    pend_q  <= pend_d;
                    tog_q   <= tog_d;
                    coal_q  <= coal_d;
                    led_q   <= led_d;
                    mode_q  <= mode_ch;
                end
            end

            // ---------------------------------------------------------------
            // Next-state logic
            // ---------------------------------------------------------------
            always_comb begin
                state_d  = state_q;
                cnt_d    = cnt_q;
                pend_d   = pend_q;
                tog_d    = tog_q;
                coal_set = 1'b0;

                if (chg) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    tog_d   = 1'b0;
                end else if (mode_ch == MODE_FLASH) begin
                    case (state_q)
                        S_IDLE: begin
                            // pend can only be set here after an ON phase
                            // ended with no gap: the one idle cycle keeps the
                            // off boundary visible before the extra flash.
                            if (pend_q) begin
                                state_d  = S_ON;
                                cnt_d    = ON_LOAD;
                                pend_d   = 1'b0;
                                coal_set = ev;
                            end else if (ev) begin
                                state_d = S_ON;
                                cnt_d   = ON_LOAD;
                            end
                        end
                        S_ON: begin
                            if (cnt_q == '0) begin
                                if (GAP_CYCLES == 0) begin
                                    state_d = S_IDLE;
                                    cnt_d   = '0;
                                end else begin
                                    state_d = S_GAP;
                                    cnt_d   = GAP_LOAD;
                                end
                            end else begin
                                cnt_d = cnt_q - CNT_ONE;
                            end
                            if (ev) begin
                                if (pend_q) begin
                                    coal_set = 1'b1;
                                end else begin
                                    pend_d = 1'b1;
                                end
                            end
                        end
                        S_GAP: begin
                            if (cnt_q == '0) begin
                                // An event in the last gap cycle restarts the
                                // flash directly, just like a pending one.
                                if (pend_q || ev) begin
                                    state_d = S_ON;
                                    cnt_d   = ON_LOAD;
                                    pend_d  = 1'b0;
                                end else begin
                                    state_d = S_IDLE;
                                end
                                coal_set = ev & pend_q;
                            end else begin
                                cnt_d = cnt_q - CNT_ONE;
                                if (ev) begin
                                    if (pend_q) begin
                                        coal_set = 1'b1;
                                    end else begin
                                        pend_d = 1'b1;
                                    end
                                end
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                            pend_d  = 1'b0;
                        end
                    endcase
                end else if (mode_ch == MODE_TOGGLE) begin
                    if (ev) begin
                        tog_d = ~tog_q;
                    end
                end

                // A merge in the same cycle as a clear keeps the flag set.
                if (coal_set) begin
                    coal_d = 1'b1;
                end else if (bus.clear_i) begin
                    coal_d = 1'b0;
                end else begin
                    coal_d = coal_q;
                end
            end

            // ---------------------------------------------------------------
            // Output logic: LED drive for the next cycle, derived from the
            // next state so the LED lights on the edge that samples the event.
            // ---------------------------------------------------------------
            always_comb begin
                under_d = 1'b0;
                if (!chg) begin
                    case (mode_ch)
                        MODE_FLASH:  under_d = (state_d == S_ON);
                        MODE_TOGGLE: under_d = tog_d;
                        MODE_LEVEL:  under_d = ev;
                        default:     under_d = 1'b0;
                    endcase
                end
                // Lamp test only overrides the drive; the channel state above
                // keeps running underneath.
                led_d = bus.lamp_test_i | under_d;
            end

            assign led_vec[gi]  = led_q;
            assign busy_vec[gi] = (state_q != S_IDLE);
            assign coal_vec[gi] = coal_q;
        end
    endgenerate

    assign bus.led_o       = led_vec;
    assign bus.busy_o      = busy_vec;
    assign bus.coalesced_o = coal_vec;

    // -----------------------------------------------------------------------
    // Optional heartbeat: free-running counter, output toggles on each wrap.
    // -----------------------------------------------------------------------
`ifdef LED_FLASH_HEARTBEAT_EN
    logic [HB_DIV-1:0] hb_cnt_q;
    logic              hb_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_q + HB_DIV'(1);
            if (&hb_cnt_q) begin
                hb_q <= ~hb_q;
            end
        end
    end

    assign heartbeat_o = hb_q;
`endif

endmodule : led_flash_bank
